// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the WB stage has priority, the MDU is
// served on idle cycles or after forcing a stall; it also tracks pending MDU dsts.
module rf_wb_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_wb_valid,
   input  logic [4:0]  pipe_wb_dst,
   input  logic [31:0] pipe_wb_data,
   output logic        pipe_stall,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_dst,
   input  logic [31:0] mdu_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_dst,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic        RFWr,
   output logic [4:0]  WB_Dst,
   output logic [31:0] WB_Result
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_PIPE,
      GNT_MDU
   } grant_e;

   grant_e      grant;
   logic        mdu_hs;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_cnt_next;
   logic [31:0] pending;
   logic [31:0] pending_next;
   logic [31:0] set_vec;
   logic [31:0] clr_vec;

   // While stalled the pipeline replays its write, so only the MDU competes.
   always_comb begin
      grant = GNT_NONE;
      if (pipe_stall) begin
         if (mdu_valid) grant = GNT_MDU;
      end else if (pipe_wb_valid) begin
         grant = GNT_PIPE;
      end else if (mdu_valid) begin
         grant = GNT_MDU;
      end
   end

   assign mdu_ready = (grant == GNT_MDU) & ~rst;
   assign mdu_hs    = mdu_valid & mdu_ready;

   always_comb begin
      wait_cnt_next = '0;
      if (mdu_valid & ~mdu_ready) begin
         if (wait_cnt >= MAX_W)
            wait_cnt_next = MAX_W;
         else
            wait_cnt_next = wait_cnt + 4'd1;
      end
   end

   // A same-cycle issue to the retiring register re-marks it outstanding.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_valid) set_vec[iss_dst] = 1'b1;
      if (mdu_hs)    clr_vec[mdu_dst] = 1'b1;
      pending_next    = (pending & ~clr_vec) | set_vec;
      pending_next[0] = 1'b0;
   end

   assign rs_busy = pending[ID_rs] & ~(mdu_hs & (mdu_dst == ID_rs));
   assign rt_busy = pending[ID_rt] & ~(mdu_hs & (mdu_dst == ID_rt));

   always_ff @(posedge clk) begin
      if (rst) begin
         RFWr       <= 1'b0;
         WB_Dst     <= '0;
         WB_Result  <= '0;
         pipe_stall <= 1'b0;
         wait_cnt   <= '0;
         pending    <= '0;
      end else begin
         wait_cnt   <= wait_cnt_next;
         pipe_stall <= (wait_cnt_next >= MAX_W);
         pending    <= pending_next;
         RFWr       <= 1'b0;
         unique case (grant)
            GNT_PIPE: begin
               RFWr      <= (pipe_wb_dst != 5'd0);
               WB_Dst    <= pipe_wb_dst;
               WB_Result <= pipe_wb_data;
            end
            GNT_MDU: begin
               RFWr      <= (mdu_dst != 5'd0);
               WB_Dst    <= mdu_dst;
               WB_Result <= mdu_data;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised scoreboard bench for rf_wb_arbiter against a cycle-level
// reference model built from the arbitration and scoreboard rules.
module tb_rf_wb_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_wb_valid;
   logic [4:0]  pipe_wb_dst;
   logic [31:0] pipe_wb_data;
   logic        pipe_stall;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_dst;
   logic [31:0] mdu_data;
   logic        iss_valid;
   logic [4:0]  iss_dst;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        rs_busy;
   logic        rt_busy;
   logic        RFWr;
   logic [4:0]  WB_Dst;
   logic [31:0] WB_Result;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_wb_valid(pipe_wb_valid), .pipe_wb_dst(pipe_wb_dst),
      .pipe_wb_data(pipe_wb_data), .pipe_stall(pipe_stall),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
      .mdu_dst(mdu_dst), .mdu_data(mdu_data),
      .iss_valid(iss_valid), .iss_dst(iss_dst),
      .ID_rs(ID_rs), .ID_rt(ID_rt),
      .rs_busy(rs_busy), .rt_busy(rt_busy),
      .RFWr(RFWr), .WB_Dst(WB_Dst), .WB_Result(WB_Result)
   );

   typedef struct {
      bit        rfwr;
      bit [4:0]  dst;
      bit [31:0] data;
      bit        stall;
      bit        ready;
      bit        rsb;
      bit        rtb;
   } exp_t;

   exp_t expq[$];
   int   compared   = 0;
   int   mismatched = 0;

   // reference model state
   bit        pend[32];
   int        starve;
   bit        m_stall;
   bit        m_rfwr;
   bit [4:0]  m_dst;
   bit [31:0] m_data;
   bit        mdu_waiting;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            check("RFWr", RFWr, e.rfwr);
            check("WB_Dst", WB_Dst, e.dst);
            check("WB_Result", WB_Result, e.data);
            check("pipe_stall", pipe_stall, e.stall);
            check("mdu_ready", mdu_ready, e.ready);
            check("rs_busy", rs_busy, e.rsb);
            check("rt_busy", rt_busy, e.rtb);
         end
      end
   end

   task automatic model_clear();
      foreach (pend[i]) pend[i] = 1'b0;
      starve      = 0;
      m_stall     = 1'b0;
      m_rfwr      = 1'b0;
      m_dst       = '0;
      m_data      = '0;
      mdu_waiting = 1'b0;
   endtask

   task automatic step(input bit r,
                       input bit pv, input bit [4:0] pd, input bit [31:0] pdat,
                       input bit mv, input bit [4:0] md, input bit [31:0] mdat,
                       input bit iv, input bit [4:0] idst,
                       input bit [4:0] rs, input bit [4:0] rt);
      exp_t e;
      int   g;
      bit   hs;
      @(posedge clk);
      #1;
      rst = r;
      pipe_wb_valid = pv; pipe_wb_dst = pd; pipe_wb_data = pdat;
      mdu_valid = mv; mdu_dst = md; mdu_data = mdat;
      iss_valid = iv; iss_dst = idst;
      ID_rs = rs; ID_rt = rt;
      // 0: nobody, 1: pipeline, 2: MDU
      if (r)            g = 0;
      else if (m_stall) g = mv ? 2 : 0;
      else if (pv)      g = 1;
      else if (mv)      g = 2;
      else              g = 0;
      hs = (g == 2);
      e.rfwr  = m_rfwr;
      e.dst   = m_dst;
      e.data  = m_data;
      e.stall = m_stall;
      e.ready = hs;
      e.rsb   = pend[rs] && !(hs && md == rs);
      e.rtb   = pend[rt] && !(hs && md == rt);
      expq.push_back(e);
      if (r) begin
         model_clear();
      end else begin
         if (g == 1) begin
            m_rfwr = (pd != 0); m_dst = pd; m_data = pdat;
         end else if (g == 2) begin
            m_rfwr = (md != 0); m_dst = md; m_data = mdat;
         end else begin
            m_rfwr = 1'b0;
         end
         if (mv && !hs) starve = (starve < MAX_WAIT) ? starve + 1 : MAX_WAIT;
         else           starve = 0;
         m_stall = (starve >= MAX_WAIT);
         if (hs) pend[md] = 1'b0;
         if (iv && idst != 0) pend[idst] = 1'b1;
         mdu_waiting = mv && !hs;
      end
   endtask

   task automatic idle(input bit [4:0] rs, input bit [4:0] rt);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, rs, rt);
   endtask

   bit        r_pv;
   bit [4:0]  r_pd;
   bit [31:0] r_pdat;
   bit        r_mv;
   bit [4:0]  r_md;
   bit [31:0] r_mdat;

   initial begin
      bit        r;
      bit        iv;
      bit [4:0]  idst;
      bit [4:0]  rs;
      bit [4:0]  rt;
      rst = 1'b1;
      pipe_wb_valid = 0; pipe_wb_dst = 0; pipe_wb_data = 0;
      mdu_valid = 0; mdu_dst = 0; mdu_data = 0;
      iss_valid = 0; iss_dst = 0; ID_rs = 0; ID_rt = 0;
      model_clear();
      @(posedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0, 0);

      // pipeline write, MDU idle
      step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
      idle(5, 0);

      // MDU write to a pending destination
      step(0, 0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
      step(0, 0, 0, 0, 1, 8, 32'h12345678, 0, 0, 8, 8);
      idle(8, 8);

      // busy lifetime of an issued op
      step(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
      for (int i = 0; i < 5; i++) idle(3, 3);
      step(0, 0, 0, 0, 1, 3, 32'hC0FFEE03, 0, 0, 3, 3);
      idle(3, 3);

      // starvation: both held until the MDU is forced through
      for (int i = 0; i < 8; i++)
         step(0, 1, 10, 32'hAAAA0010, (i == 0) || mdu_waiting, 12,
              32'hBBBB0012, 0, 0, 12, 10);
      idle(0, 0);

      // same-cycle set and clear of one register
      step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      step(0, 0, 0, 0, 1, 9, 32'h99999999, 1, 9, 9, 9);
      idle(9, 9);
      step(0, 0, 0, 0, 1, 9, 32'h9999AAAA, 0, 0, 9, 0);
      idle(9, 9);

      // dst 0 handshake, then reset with registers pending
      step(0, 0, 0, 0, 1, 0, 32'h00000BAD, 0, 0, 0, 0);
      idle(0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 8, 4, 8);
      step(1, 1, 7, 32'h77777777, 1, 4, 32'h44444444, 0, 0, 4, 8);
      idle(4, 8);

      // randomised traffic honouring the source contracts
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         if (!m_stall) begin
            r_pv   = ($urandom_range(0, 2) != 0);
            r_pd   = 5'($urandom);
            r_pdat = $urandom;
         end
         if (!mdu_waiting) begin
            r_mv = ($urandom_range(0, 2) == 0);
            r_md = 5'($urandom);
            for (int k = 0; k < 8 && !pend[r_md]; k++) r_md = 5'($urandom);
            r_mdat = $urandom;
         end
         idst = 5'($urandom);
         iv   = ($urandom_range(0, 3) == 0) && !pend[idst];
         rs   = 5'($urandom);
         rt   = ($urandom_range(0, 1) == 0) ? r_md : 5'($urandom);
         step(r, r_pv, r_pd, r_pdat, r_mv, r_md, r_mdat, iv, idst, rs, rt);
         if (r) begin
            r_pv = 1'b0;
            r_mv = 1'b0;
         end
      end

      idle(0, 0);
      idle(0, 0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences all writes into the single register-file write port (RFWr / WB_Dst / WB_Result).
- Sources: the in-order pipeline WB stage (priority) and the multi-cycle MUL/DIV unit (valid/ready).
- Holds a 32-entry pending scoreboard for long-latency destinations, so ID can stall on operands that are not yet written.
- Sits between the WB stage / MDU and the RF write port; its scoreboard is read by ID.

Parameters:
- MAX_WAIT, 4, consecutive cycles the MDU may be refused before the arbiter forces a pipeline stall (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pipe_wb_valid  in  1  pipeline WB stage holds a register write
- pipe_wb_dst  in  5  pipeline destination register
- pipe_wb_data  in  32  pipeline write data
- pipe_stall  out  1  pipeline must freeze WB and re-present the same write next cycle
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  MDU result accepted this cycle
- mdu_dst  in  5  MDU destination register
- mdu_data  in  32  MDU result
- iss_valid  in  1  a long-latency MDU op issues this cycle
- iss_dst  in  5  destination of the issuing op
- ID_rs  in  5  ID source register A
- ID_rt  in  5  ID source register B
- rs_busy  out  1  ID_rs has an outstanding MDU write
- rt_busy  out  1  ID_rt has an outstanding MDU write
- RFWr  out  1  RF write enable
- WB_Dst  out  5  RF write address
- WB_Result  out  32  RF write data

Behaviour:
- Reset (synchronous, active-high):
  - RFWr, WB_Dst, WB_Result, pipe_stall = 0.
  - wait_cnt = 0; pending = 0.
  - mdu_ready = 0 during the reset cycle.
- Grant, combinational, each cycle:
  - pipe_stall=1: grant MDU if mdu_valid; pipe_wb_valid is ignored because the pipeline replays its write.
  - else pipe_wb_valid=1: grant pipe; mdu_ready=0.
  - else mdu_valid=1: grant MDU; mdu_ready=1.
  - else: no grant.
- Output stage, registered, 1-cycle latency:
  - Cycle after a grant: RFWr = 1 iff granted dst != 0; WB_Dst/WB_Result = granted dst/data.
  - No grant: RFWr = 0; WB_Dst/WB_Result hold their previous values.
  - Dst 0 completes its handshake (mdu_ready=1) but never asserts RFWr.
- Starvation counter (wait_cnt, 4 bits):
  - mdu_valid & ~mdu_ready: increment, saturating at MAX_WAIT.
  - MDU granted, or mdu_valid=0: reset to 0.
- pipe_stall:
  - Registered: next-cycle value = (wait_cnt_next >= MAX_WAIT).
  - Falls the cycle after the MDU grant.
  - Never high for more than one consecutive cycle while the MDU is held valid.
- Scoreboard pending[31:0]:
  - Set pending[iss_dst] when iss_valid & iss_dst != 0.
  - Clear pending[mdu_dst] on an MDU handshake (mdu_valid & mdu_ready).
  - Same register set and cleared in the same cycle: set wins (new op outstanding).
  - pending[0] is always 0.
- Busy flags:
  - rs_busy = pending[ID_rs] & ~(mdu handshake this cycle & mdu_dst == ID_rs); rt_busy likewise.
  - A result written this cycle is not reported busy; ID then reads it via WB forwarding the next cycle.
- Contracts, not checked:
  - Issuer never issues to a register already pending.
  - MDU holds mdu_dst/mdu_data stable while mdu_valid & ~mdu_ready.
  - Pipeline freezes WB while pipe_stall=1.
- Reset mid-operation: pending, wait_cnt and outputs clear; any in-flight MDU result is dropped. The MDU is reset by the same rst.

Test Plan:
- Idle MDU; pipe writes dst=5, data=0xDEADBEEF at cycle t -> at t+1 RFWr=1, WB_Dst=5, WB_Result=0xDEADBEEF; mdu_ready stays 0.
- Pipe idle; MDU valid dst=8, data=0x12345678 -> mdu_ready=1 same cycle; RFWr=1, WB_Dst=8 next cycle; pending[8] cleared.
- MAX_WAIT=4; pipe_wb_valid held 1 and mdu_valid held 1 from t -> pipe_stall=1 at t+4; MDU granted at t+4; RFWr with MDU dst at t+5; pipe_stall=0 at t+5; pipe write resumes at t+5 and is committed at t+6.
- iss_valid dst=3 at t -> rs_busy=1 for ID_rs=3 from t+1. MDU handshake dst=3 at t+6 -> rs_busy=0 in t+6 and after.
- Same cycle: iss_valid dst=9 and MDU handshake dst=9 (pending already set) -> pending[9] remains 1; RFWr=1, WB_Dst=9 next cycle.
- MDU handshake with dst=0 -> mdu_ready=1; RFWr=0 next cycle. Then assert rst with pending=0x0000_0110 -> after the reset cycle pending=0, RFWr=0, pipe_stall=0.
